// File: rtl/shift_rr_pkg.sv
// Shared definitions for the two-requester shift/rotate scheduler.
//   DATA_W       operand / result word width
//   OP_*         2-bit operation encodings
//   buf_state_e  one-entry result buffer state
package shift_rr_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_ROTR = 2'b10;
   localparam logic [1:0] OP_ROTL = 2'b11;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/shift_rr_dp.sv
// Combinational 32-bit shift/rotate datapath with a 64-bit result.
// Ports:
//   op        in   2   OP_SLL / OP_SRL / OP_ROTR / OP_ROTL
//   a         in  32   operand
//   b         in  32   amount; b[5:0] for shifts, b[4:0] for rotates
//   res_high  out 32   upper result word (shifts only, 0 for rotates)
//   res_low   out 32   lower result word
module shift_rr_dp
   import shift_rr_pkg::*;
(
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] res_high,
   output logic [DATA_W-1:0] res_low
);

   logic [5:0]          n;
   logic [4:0]          r;
   logic [2*DATA_W-1:0] sll_w;
   logic [2*DATA_W-1:0] srl_w;
   logic [2*DATA_W-1:0] rotr_w;
   logic [2*DATA_W-1:0] rotl_w;
   logic                unused_bits;

   assign n = b[5:0];
   assign r = b[4:0];

   assign sll_w = {{DATA_W{1'b0}}, a} << n;
   assign srl_w = {a, {DATA_W{1'b0}}} >> n;

   // Rotating a doubled word turns a rotate into a plain shift; the wanted
   // word is the low half for right and the high half for left.
   assign rotr_w = {a, a} >> r;
   assign rotl_w = {a, a} << r;

   assign unused_bits = ^{b[DATA_W-1:6], rotr_w[2*DATA_W-1:DATA_W], rotl_w[DATA_W-1:0]};

   always_comb begin
      res_high = '0;
      res_low  = '0;
      case (op)
         OP_SLL: begin
            res_high = sll_w[2*DATA_W-1:DATA_W];
            res_low  = sll_w[DATA_W-1:0];
         end
         OP_SRL: begin
            res_high = srl_w[2*DATA_W-1:DATA_W];
            res_low  = srl_w[DATA_W-1:0];
         end
         OP_ROTR: res_low = rotr_w[DATA_W-1:0];
         default: res_low = rotl_w[2*DATA_W-1:DATA_W];
      endcase
   end

endmodule

// File: rtl/shift_rr_sched.sv
// Two-requester round-robin scheduler in front of one shared shift/rotate
// datapath, with a one-entry registered result buffer.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   BUF_EMPTY | no result held; any valid request is accepted
//   BUF_FULL  | result held on rsp_*; accept only if rsp_ready
//
// Ports:
//   clock, reset_n              clock, async active-low reset
//   reqN_valid/ready            request handshake, N = 0,1
//   reqN_op, reqN_a, reqN_b     operation, operand, amount
//   rsp_valid/ready             response handshake
//   rsp_id                      requester that issued the held result
//   rsp_res_high, rsp_res_low   64-bit result
//   stat_grant0/1               saturating grant counters, present only
//                               when SHIFT_RR_SCHED_STATS_EN is defined
// Parameters: STAT_W counter width, RR_EN 1=round-robin / 0=req0 priority.
module shift_rr_sched
   import shift_rr_pkg::*;
#(
   parameter int unsigned STAT_W = 16,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [1:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [1:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_res_high,
`ifdef SHIFT_RR_SCHED_STATS_EN
   output logic [DATA_W-1:0] rsp_res_low,
   output logic [STAT_W-1:0] stat_grant0,
   output logic [STAT_W-1:0] stat_grant1
`else
   output logic [DATA_W-1:0] rsp_res_low
`endif
);

   buf_state_e        state_q, state_d;
   logic              last_q, last_d;
   logic              id_q, id_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   logic              can_accept;
   logic              grant;
   logic              accept;
   logic [1:0]        sel_op;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic [DATA_W-1:0] dp_high;
   logic [DATA_W-1:0] dp_low;

   assign can_accept = (state_q == BUF_EMPTY) || rsp_ready;

   // last_q names the requester granted last; the other one wins a tie.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = RR_EN ? ~last_q : 1'b0;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // reset_n gates the handshake so neither requester sees ready in reset.
   assign accept     = reset_n && can_accept && (req0_valid || req1_valid);
   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;

   assign sel_op = grant ? req1_op : req0_op;
   assign sel_a  = grant ? req1_a  : req0_a;
   assign sel_b  = grant ? req1_b  : req0_b;

   shift_rr_dp u_dp (
      .op       (sel_op),
      .a        (sel_a),
      .b        (sel_b),
      .res_high (dp_high),
      .res_low  (dp_low)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (accept) begin
         state_d = BUF_FULL;
         last_d  = grant;
         id_d    = grant;
         hi_d    = dp_high;
         lo_d    = dp_low;
      end else if ((state_q == BUF_FULL) && rsp_ready) begin
         state_d = BUF_EMPTY;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BUF_EMPTY;
         last_q  <= 1'b0;
         id_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign rsp_valid    = (state_q == BUF_FULL);
   assign rsp_id       = id_q;
   assign rsp_res_high = hi_q;
   assign rsp_res_low  = lo_q;

`ifdef SHIFT_RR_SCHED_STATS_EN
   logic [STAT_W-1:0] cnt0_q, cnt0_d;
   logic [STAT_W-1:0] cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (req0_ready && (cnt0_q != {STAT_W{1'b1}})) cnt0_d = cnt0_q + 1'b1;
      if (req1_ready && (cnt1_q != {STAT_W{1'b1}})) cnt1_d = cnt1_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign stat_grant0 = cnt0_q;
   assign stat_grant1 = cnt1_q;
`else
   logic [STAT_W-1:0] unused_stat;
   assign unused_stat = '0;
`endif

endmodule

// File: tb/tb_shift_rr_sched.sv
module tb_shift_rr_sched;
   import shift_rr_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req0_valid, req0_ready;
   logic [1:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [1:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_res_high, rsp_res_low;
`ifdef SHIFT_RR_SCHED_STATS_EN
   logic [15:0] stat_grant0, stat_grant1;
`endif

   shift_rr_sched #(.STAT_W(16), .RR_EN(1'b1)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_op      (req0_op),
      .req0_a       (req0_a),
      .req0_b       (req0_b),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_op      (req1_op),
      .req1_a       (req1_a),
      .req1_b       (req1_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_res_high (rsp_res_high),
`ifdef SHIFT_RR_SCHED_STATS_EN
      .rsp_res_low  (rsp_res_low),
      .stat_grant0  (stat_grant0),
      .stat_grant1  (stat_grant1)
`else
      .rsp_res_low  (rsp_res_low)
`endif
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   bit          m_full;
   bit          m_id;
   bit          m_last;
   logic [31:0] m_hi, m_lo;
   int          m_cnt0, m_cnt1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Result from the arithmetic definitions: shifts on a 64-bit field,
   // rotates as repeated single-bit rotations.
   function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] w;
      logic [31:0] x;
      int          n, r;
      n = int'(b[5:0]);
      r = int'(b[4:0]);
      x = a;
      case (op)
         OP_SLL: w = {32'h0, a} << n;
         OP_SRL: w = {a, 32'h0} >> n;
         OP_ROTR: begin
            for (int i = 0; i < r; i++) x = {x[0], x[31:1]};
            w = {32'h0, x};
         end
         default: begin
            for (int i = 0; i < r; i++) x = {x[30:0], x[31]};
            w = {32'h0, x};
         end
      endcase
      return w;
   endfunction

   function automatic void model_reset();
      m_full = 0; m_id = 0; m_last = 0; m_hi = '0; m_lo = '0;
      m_cnt0 = 0; m_cnt1 = 0;
   endfunction

   task automatic check_rsp();
      chk("rsp_valid", {63'h0, rsp_valid}, {63'h0, m_full});
      if (m_full) begin
         chk("rsp_id", {63'h0, rsp_id}, {63'h0, m_id});
         chk("rsp_res_high", {32'h0, rsp_res_high}, {32'h0, m_hi});
         chk("rsp_res_low", {32'h0, rsp_res_low}, {32'h0, m_lo});
      end
   endtask

   // Called just after a falling edge; drives one cycle, checks the
   // handshake, advances the model and checks the response after the edge.
   task automatic step(input logic v0, input logic [1:0] o0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic v1, input logic [1:0] o1,
                       input logic [31:0] a1, input logic [31:0] b1, input logic rdy);
      bit          acc, g;
      logic [63:0] r;
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      rsp_ready  = rdy;
      #1;
      acc = (!m_full || rdy) && (v0 || v1);
      if (v0 && v1) g = !m_last;
      else          g = v1;
      chk("req0_ready", {63'h0, req0_ready}, {63'h0, acc && !g});
      chk("req1_ready", {63'h0, req1_ready}, {63'h0, acc && g});
      if (acc) begin
         r      = g ? ref_res(o1, a1, b1) : ref_res(o0, a0, b0);
         m_full = 1;
         m_id   = g;
         m_last = g;
         m_hi   = r[63:32];
         m_lo   = r[31:0];
         if (g) begin if (m_cnt1 < 65535) m_cnt1++; end
         else   begin if (m_cnt0 < 65535) m_cnt0++; end
      end else if (m_full && rdy) begin
         m_full = 0;
      end
      @(negedge clock);
      check_rsp();
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
      rsp_ready  = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 0;
      repeat (2) @(negedge clock);
      reset_n = 1;
      model_reset();
   endtask

   logic [31:0] hold_hi, hold_lo;

   initial begin
      idle_inputs();
      do_reset();
      chk("reset_valid", {63'h0, rsp_valid}, 64'h0);
      chk("reset_res", {rsp_res_high, rsp_res_low}, 64'h0);

      // single ops, directed values
      step(1, OP_ROTR, 32'h80000001, 32'd1, 0, OP_SLL, 0, 0, 0);
      chk("rotr_low", {32'h0, rsp_res_low}, 64'hC0000000);
      chk("rotr_id", {63'h0, rsp_id}, 64'h0);
      step(0, OP_SLL, 0, 0, 1, OP_ROTL, 32'h80000001, 32'd33, 1);
      chk("rotl_low", {32'h0, rsp_res_low}, 64'h3);
      chk("rotl_id", {63'h0, rsp_id}, 64'h1);
      step(1, OP_SLL, 32'hF0000001, 32'd4, 0, OP_SLL, 0, 0, 1);
      chk("sll4", {rsp_res_high, rsp_res_low}, 64'h0000000F_00000010);
      step(1, OP_SRL, 32'h0000000F, 32'd4, 0, OP_SLL, 0, 0, 1);
      chk("srl4", {rsp_res_high, rsp_res_low}, 64'h00000000_F0000000);
      step(1, OP_SLL, 32'h000000FF, 32'd40, 0, OP_SLL, 0, 0, 1);
      chk("sll40", {rsp_res_high, rsp_res_low}, 64'h0000FF00_00000000);
      step(0, OP_SLL, 0, 0, 0, OP_SLL, 0, 0, 1);

      // reset while a result is held
      step(1, OP_ROTR, 32'h12345678, 32'd8, 0, OP_SLL, 0, 0, 0);
      req0_valid = 1; req1_valid = 1; rsp_ready = 0;
      reset_n = 0;
      #1;
      chk("rst_async_valid", {63'h0, rsp_valid}, 64'h0);
      chk("rst_async_res", {31'h0, rsp_id, rsp_res_high, rsp_res_low}, 64'h0);
      chk("rst_ready", {62'h0, req0_ready, req1_ready}, 64'h0);
      @(negedge clock);
      reset_n = 1;
      model_reset();
      step(1, OP_SLL, 32'h1, 32'd1, 1, OP_SRL, 32'h2, 32'd1, 1);
      chk("rst_then_req1", {63'h0, rsp_id}, 64'h1);

      // continuous contention: grants alternate starting with req1
      do_reset();
      for (int k = 0; k < 8; k++) begin
         step(1, OP_SLL, 32'h1, k, 1, OP_ROTL, 32'hA5A5A5A5, k, 1);
         chk("rr_alt", {63'h0, rsp_id}, (k % 2 == 0) ? 64'h1 : 64'h0);
      end
`ifdef SHIFT_RR_SCHED_STATS_EN
      chk("stat_grant0", {48'h0, stat_grant0}, 64'd4);
      chk("stat_grant1", {48'h0, stat_grant1}, 64'd4);
`endif

      // back-pressure with a full buffer
      step(1, OP_ROTL, 32'hDEADBEEF, 32'd7, 0, OP_SLL, 0, 0, 0);
      hold_hi = m_hi;
      hold_lo = m_lo;
      for (int k = 0; k < 3; k++) begin
         step(1, OP_SRL, 32'hFFFF0000, k, 1, OP_SLL, 32'h0000FFFF, k, 0);
         chk("bp_stable", {rsp_res_high, rsp_res_low}, {hold_hi, hold_lo});
      end
      step(1, OP_SRL, 32'hFFFF0000, 32'd3, 1, OP_SLL, 32'h0000FFFF, 32'd3, 1);
      step(0, OP_SLL, 0, 0, 0, OP_SLL, 0, 0, 1);

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom,
              $urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom,
              $urandom_range(0, 2) != 0);
      end
`ifdef SHIFT_RR_SCHED_STATS_EN
      chk("stat_grant0_rand", {48'h0, stat_grant0}, 64'(m_cnt0));
      chk("stat_grant1_rand", {48'h0, stat_grant1}, 64'(m_cnt1));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_rr_sched.md
Name: shift_rr_sched

Overview:
- Two-requester scheduler that shares one 32-bit shift/rotate datapath (SLL, SRL, ROTR, ROTL).
- Round-robin arbitration with valid/ready handshakes on both requesters and on the response side.
- One-entry registered result buffer, so a single op is in flight at any time; this buffer provides the back-pressure.
- Sits between issue logic and the shared shifter, in place of per-requester shift units.

Parameters:
- STAT_W, 16, width of the optional grant counters (used only with SHIFT_RR_SCHED_STATS_EN).
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, req0 always wins.

Ports:
- clock  in  1  single rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_op  in  2  00 SLL, 01 SRL, 10 ROTR, 11 ROTL.
- req0_a  in  32  operand.
- req0_b  in  32  shift amount (only the low bits are used).
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  result buffer holds a result.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  index of the requester that issued the result.
- rsp_res_high  out  32  upper result word.
- rsp_res_low  out  32  lower result word.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - rsp_valid=0, rsp_id=0, rsp_res_high=0, rsp_res_low=0.
  - Round-robin pointer = 0, so req1 has priority next (req0 was "last granted").
  - A result held at reset is discarded.
  - Both ready outputs are 0 while reset_n=0.
- Buffer states: EMPTY and FULL.
  - can_accept = EMPTY, or (FULL and rsp_ready).
  - ready outputs depend combinationally on rsp_ready.
- Grant, computed combinationally:
  - Only one requester valid: it is granted.
  - Both valid, RR_EN=1: the requester not granted last wins.
  - Both valid, RR_EN=0: req0 wins.
  - reqN_ready = can_accept and grant==N; at most one ready is high per cycle.
- Accept: op, a and b are computed by the internal datapath in the same cycle and registered.
  - Result appears with rsp_valid=1 on the next cycle (latency 1).
  - Throughput is 1 op/cycle when rsp_ready is held high.
  - The round-robin pointer updates only on an accept.
- Response: rsp_* are stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid and rsp_ready both high: the buffer drains; it reloads in the same cycle if a new op is accepted.
- Datapath arithmetic, n = b[5:0] for shifts and r = b[4:0] for rotates; b[31:6] is ignored:
  - SLL: {res_high,res_low} = {32'h0,a} << n.
  - SRL: {res_high,res_low} = {a,32'h0} >> n; the logical result is res_high and the shifted-out bits are in res_low.
  - ROTR: res_low = (a>>r) | (a<<(32-r)), res_high = 0.
  - ROTL: res_low = (a<<r) | (a>>(32-r)), res_high = 0.
  - r=0 returns a for both rotates; n=0 gives {0,a} for SLL and {a,0} for SRL.
- Boundaries:
  - No valid request: no ready, no state change.
  - A requester may drop valid without being granted; no state is held for it.
  - A requester that holds valid while waiting is granted within 2 accept opportunities when RR_EN=1.

Optional Feature:
- Macro: SHIFT_RR_SCHED_STATS_EN.
- Defined:
  - Adds outputs stat_grant0 and stat_grant1, each [STAT_W-1:0].
  - Each counter increments once per accept of its requester and saturates at all-ones.
  - Both clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package shift_rr_pkg:
  - op encoding constants OP_SLL=2'b00, OP_SRL=2'b01, OP_ROTR=2'b10, OP_ROTL=2'b11.
  - localparam DATA_W=32.
  - buffer-state encoding.
- One sub-module: shift_rr_dp.
  - Purely combinational; inputs op, a, b; outputs res_high, res_low.
  - Implements the arithmetic above.
  - The scheduler instantiates it once and registers its outputs.

Test Plan:
- Reset mid-op: accept ROTR on req0, then pulse reset_n low before rsp_ready.
  - Required: rsp_valid=0 and rsp_* =0 immediately (asynchronous); the next accept after release grants req1 if both are valid.
- req0 ROTR a=0x80000001 b=1.
  - Required: after 1 cycle, rsp_valid=1, rsp_id=0, res_low=0xC0000000, res_high=0.
- req1 ROTL a=0x80000001 b=33.
  - Required: r=1, res_low=0x00000003, rsp_id=1.
- SLL a=0xF0000001 b=4 gives high=0x0000000F, low=0x00000010.
- SRL a=0x0000000F b=4 gives high=0x00000000, low=0xF0000000.
- SLL a=0x000000FF b=40 gives high=0x0000FF00, low=0.
- Both requesters valid continuously, rsp_ready=1, RR_EN=1.
  - Required: grants alternate 1,0,1,0 for 8 cycles, with the result each cycle.
  - With SHIFT_RR_SCHED_STATS_EN: stat_grant0=4, stat_grant1=4.
- Back-pressure: rsp_ready=0 for 3 cycles with FULL.
  - Required: both ready=0 and rsp_* stable.
  - When rsp_ready rises, drain and accept occur in the same cycle and the new result appears on the next cycle.
